// File: rtl/inst_buffer_pkg.sv
// Shared definitions for the fetch-to-dispatch instruction buffer:
// superscalar width, per-cycle count width and the fetched packet layout.
package inst_buffer_pkg;

    // Superscalar width: packets moved per cycle on each side of the buffer.
    localparam int N = 3;

    // Wide enough to hold every per-cycle count from 0 to N inclusive.
    localparam int NUM_SCALAR_BITS = $clog2(N + 1);

    // One fetched instruction together with its fetch PC and predicted direction.
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] PC;
        logic        taken;
    } FETCH_PACKET;

endpackage

// File: rtl/inst_buffer_if.sv
// Fetch- and dispatch-side signals of the instruction buffer.
// The master side is fetch/dispatch/execute; the slave side is the buffer.
interface inst_buffer_if;
    import inst_buffer_pkg::*;

    FETCH_PACKET [N-1:0]        inst_buffer_inputs;
    logic [NUM_SCALAR_BITS-1:0] instructions_valid;
    logic [NUM_SCALAR_BITS-1:0] inst_buffer_spots;
    logic                       restore_valid;
    logic [NUM_SCALAR_BITS-1:0] num_dispatched;
    FETCH_PACKET [N-1:0]        dispatch_packets;
    logic [NUM_SCALAR_BITS-1:0] dispatch_count;

    modport master (
        output inst_buffer_inputs, instructions_valid, restore_valid, num_dispatched,
        input  inst_buffer_spots, dispatch_packets, dispatch_count
    );

    modport slave (
        input  inst_buffer_inputs, instructions_valid, restore_valid, num_dispatched,
        output inst_buffer_spots, dispatch_packets, dispatch_count
    );

endinterface

// File: rtl/inst_buffer.sv
// Circular instruction buffer between fetch and dispatch.
// Accepts up to N packets per cycle, presents the oldest up to N packets,
// advertises min(free, N) spots from the registered occupancy, and empties
// on a mispredict restore.
// Optional: define INST_BUFFER_DEBUG_EN to add debug_count (live occupancy)
// and debug_overflow (sticky illegal-request flag, cleared only by reset).
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic         clock,
    input  logic         reset,
    inst_buffer_if.slave ib
`ifdef INST_BUFFER_DEBUG_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] debug_count,
    output logic                       debug_overflow
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    FETCH_PACKET      entries [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] enq_n;
    logic [CNT_W-1:0] deq_n;
    logic [CNT_W-1:0] free_cnt;

    assign enq_n    = CNT_W'(ib.instructions_valid);
    assign deq_n    = CNT_W'(ib.num_dispatched);
    assign free_cnt = CNT_W'(DEPTH) - count;

    // Write incoming packets at consecutive slots starting from tail.
    // NOTE: the entry array carries no reset; head/tail/count define which slots are live.
    always_ff @(posedge clock) begin
        if (!reset && !ib.restore_valid) begin
            for (int i = 0; i < N; i++) begin
                if (i < int'(ib.instructions_valid)) begin
                    entries[tail + PTR_W'(i)] <= ib.inst_buffer_inputs[i];
                end
            end
        end
    end

    // Pointer and occupancy update: reset, then restore flush, then enqueue/dequeue.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset || ib.restore_valid) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(ib.num_dispatched);
            tail  <= tail + PTR_W'(ib.instructions_valid);
            count <= count + enq_n - deq_n;
        end
    end

    // Outputs depend on registered state only: spots, visible count and head packets.
    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        ib.dispatch_packets  = '0;
        ib.inst_buffer_spots = (free_cnt >= CNT_W'(N)) ? NUM_SCALAR_BITS'(N)
                                                       : NUM_SCALAR_BITS'(free_cnt);
        ib.dispatch_count    = (count >= CNT_W'(N)) ? NUM_SCALAR_BITS'(N)
                                                    : NUM_SCALAR_BITS'(count);
        for (int i = 0; i < N; i++) begin
            if (CNT_W'(i) < count) begin
                ib.dispatch_packets[i] = entries[head + PTR_W'(i)];
            end
        end
    end

`ifdef INST_BUFFER_DEBUG_EN
    assign debug_count = count;

    // Sticky flag for fetch or dispatch exceeding what the buffer advertised.
    always_ff @(posedge clock) begin
        if (reset) begin
            debug_overflow <= 1'b0;
        end else if ((ib.instructions_valid > ib.inst_buffer_spots) ||
                     (ib.num_dispatched > ib.dispatch_count)) begin
            debug_overflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_buffer.sv
// Self-checking bench for inst_buffer (N=3, DEPTH=8): directed steps followed
// by random legal traffic, checked against a queue-based reference model.
module tb_inst_buffer;
    import inst_buffer_pkg::*;

    localparam int DEPTH = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;

    inst_buffer_if ib ();

`ifdef INST_BUFFER_DEBUG_EN
    logic [$clog2(DEPTH+1)-1:0] debug_count;
    logic                       debug_overflow;
`endif

    inst_buffer #(.DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .ib    (ib.slave)
`ifdef INST_BUFFER_DEBUG_EN
        ,
        .debug_count    (debug_count),
        .debug_overflow (debug_overflow)
`endif
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model: the buffer is simply an ordered list of packets.
    FETCH_PACKET q [$];
    logic [31:0] next_pc = 32'h0;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int model_spots();
        return imin(DEPTH - q.size(), N);
    endfunction

    function automatic int model_visible();
        return imin(q.size(), N);
    endfunction

    task automatic check(input string tag, input logic [95:0] observed, input logic [95:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag);
        FETCH_PACKET exp_pk;
        check({tag, ".dispatch_count"}, 96'(ib.dispatch_count), 96'(model_visible()));
        check({tag, ".spots"}, 96'(ib.inst_buffer_spots), 96'(model_spots()));
        for (int i = 0; i < N; i++) begin
            exp_pk = (i < model_visible()) ? q[i] : '0;
            check($sformatf("%s.pkt%0d", tag, i), 96'(ib.dispatch_packets[i]), 96'(exp_pk));
        end
    endtask

    // Apply one cycle of inputs, advance the model with the same inputs,
    // then check the registered outputs just after the edge.
    task automatic cycle(input string tag, input int iv, input int nd,
                         input logic rst, input logic rsv);
        FETCH_PACKET pk [N];
        for (int i = 0; i < N; i++) begin
            pk[i].inst  = $urandom;
            pk[i].taken = 1'($urandom);
            pk[i].PC    = (i < iv) ? next_pc + 32'(4 * i) : $urandom;
            ib.inst_buffer_inputs[i] = pk[i];
        end
        ib.instructions_valid = NUM_SCALAR_BITS'(iv);
        ib.num_dispatched     = NUM_SCALAR_BITS'(nd);
        ib.restore_valid      = rsv;
        reset                 = rst;
        @(posedge clock);
        if (rst || rsv) begin
            q.delete();
        end else begin
            for (int k = 0; k < nd; k++) begin
                if (q.size() > 0) void'(q.pop_front());
            end
            for (int i = 0; i < iv; i++) q.push_back(pk[i]);
            next_pc += 32'(4 * iv);
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        int iv;
        int nd;
        logic rsv;
        logic rst;

        ib.inst_buffer_inputs = '0;
        ib.instructions_valid = '0;
        ib.num_dispatched     = '0;
        ib.restore_valid      = 1'b0;

        // Reset state.
        cycle("reset0", 0, 0, 1'b1, 1'b0);
        cycle("reset1", 0, 0, 1'b1, 1'b0);
        check("reset.spots_const", 96'(ib.inst_buffer_spots), 96'(3));
        check("reset.count_const", 96'(ib.dispatch_count), 96'(0));

        // First enqueue of PCs 0x0, 0x4, 0x8 visible one cycle later.
        cycle("enq3", 3, 0, 1'b0, 1'b0);
        check("enq3.pc0", 96'(ib.dispatch_packets[0].PC), 96'(32'h0));
        check("enq3.pc2", 96'(ib.dispatch_packets[2].PC), 96'(32'h8));

        // Fill to DEPTH: 3 more then 2 (limited by spots).
        cycle("fill6", 3, 0, 1'b0, 1'b0);
        cycle("fill8", 2, 0, 1'b0, 1'b0);
        check("full.spots_const", 96'(ib.inst_buffer_spots), 96'(0));

        // Full buffer streaming 3 in / 3 out across the pointer wrap.
        for (int c = 0; c < 6; c++) begin
            cycle($sformatf("wrap%0d", c), 3, 3, 1'b0, 1'b0);
        end
        check("wrap.spots_const", 96'(ib.inst_buffer_spots), 96'(0));

        // Drop to 5 entries, then restore with a same-cycle enqueue.
        cycle("drain5", 0, 3, 1'b0, 1'b0);
        cycle("restore", 3, 2, 1'b0, 1'b1);
        check("restore.count_const", 96'(ib.dispatch_count), 96'(0));
        check("restore.spots_const", 96'(ib.inst_buffer_spots), 96'(3));

        // Redirected fetch right after restore, then balanced enq/deq of 2.
        cycle("post_restore", 2, 0, 1'b0, 1'b0);
        cycle("swap2", 2, 2, 1'b0, 1'b0);
        check("swap2.count_const", 96'(ib.dispatch_count), 96'(2));

        // Random legal traffic with occasional restore and one mid-run reset.
        for (int c = 0; c < 400; c++) begin
            iv  = $urandom_range(model_spots(), 0);
            nd  = $urandom_range(model_visible(), 0);
            rsv = ($urandom_range(15, 0) == 0);
            rst = (c == 200);
            cycle($sformatf("rand%0d", c), iv, nd, rst, rsv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
